// File: rtl/pm_load_pkg.sv
// Shared types and defaults for the program-memory load arbiter.
package pm_load_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  // Wide enough for any legal flush length (1..15).
  localparam int FLUSH_CNT_W = 4;

  // Port ownership phases: fetch owns the port only in RUN.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2,
    FLUSH = 2'd3
  } state_e;

endpackage

// File: rtl/pm_write_port.sv
// Program-memory write register stage plus the fetch pass-through mux.
module pm_write_port
  import pm_load_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pass,
  input  logic [ADDR_W-1:0] cpu_pm_address,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] pm_address,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              pm_we
);

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // An accepted byte becomes a write one cycle later; address/data hold between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= wr_en;
      if (wr_en) begin
        addr_q  <= wr_addr;
        wdata_q <= wr_data;
      end
    end
  end

  // Fetch sees the memory directly while it owns the port; no added latency.
  assign pm_address = pass ? cpu_pm_address : addr_q;
  assign pm_wdata   = wdata_q;
  assign pm_we      = we_q;

endmodule

// File: rtl/pm_load_arbiter.sv
// Shares the program-memory port between fetch and an external byte loader.
module pm_load_arbiter
  import pm_load_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] cpu_pm_address,
  output logic [ADDR_W-1:0] pm_address,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              pm_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done
);

  state_e                 state_q, state_d;
  // One extra bit so a zero length means a full-depth load.
  logic [ADDR_W:0]        rem_q;
  logic [ADDR_W-1:0]      ptr_q;
  logic [FLUSH_CNT_W-1:0] flush_q;
  logic                   done_q;
  logic                   accept;
  logic                   last;
  logic                   start;

  assign start  = (state_q == RUN) && load_req;
  assign accept = (state_q == LOAD) && ld_valid;
  assign last   = accept && (rem_q == (ADDR_W+1)'(1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    case (state_q)
      RUN:   if (load_req) state_d = DRAIN;
      // One idle held cycle lets an in-flight fetch retire before the port is taken.
      DRAIN: state_d = LOAD;
      LOAD: begin
        ld_ready = 1'b1;
        if (last) state_d = FLUSH;
      end
      FLUSH: if (flush_q == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign cpu_hold  = (state_q != RUN);
  assign busy      = (state_q != RUN);
  assign load_done = done_q;

  // Byte pointer and remaining count; pointer wraps naturally for full-depth loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      ptr_q <= '0;
    end else if (start) begin
      rem_q <= {(load_len == '0), load_len};
      ptr_q <= '0;
    end else if (accept) begin
      rem_q <= rem_q - 1'b1;
      ptr_q <= ptr_q + 1'b1;
    end
  end

  // Flush countdown: loaded on the final accept so FLUSH lasts exactly FLUSH_CYCLES.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_q <= '0;
    end else if (last) begin
      flush_q <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    end else if ((state_q == FLUSH) && (flush_q != '0)) begin
      flush_q <= flush_q - 1'b1;
    end
  end

  // Completion pulse lands in the first RUN cycle; an aborted load never raises it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_q <= 1'b0;
    else        done_q <= (state_q == FLUSH) && (flush_q == '0);
  end

  pm_write_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wport (
    .clk            (clk),
    .reset          (reset),
    .pass           (state_q == RUN),
    .cpu_pm_address (cpu_pm_address),
    .wr_en          (accept),
    .wr_addr        (ptr_q),
    .wr_data        (ld_data),
    .pm_address     (pm_address),
    .pm_wdata       (pm_wdata),
    .pm_we          (pm_we)
  );

endmodule
